bram_stream_reader: RTL

- Read-side client for one port of the team's dual-port block RAM (registered output, 1-cycle read latency).
- On a start command, fetches a frame of DATA_WIDTH-bit words from a base address (address wraps modulo 2**ADDR_WIDTH) and streams them out on a valid/ready interface.
- An internal 2-entry skid FIFO absorbs the RAM read latency under backpressure.
- Sits between the packet buffer RAM and the TX/MAC-side consumer.

---
 rtl/bram_stream_reader_pkg.sv | 19 +
 rtl/bram_stream_reader_if.sv | 14 +
 rtl/bram_stream_reader_skid_fifo2.sv | 66 ++++++
 rtl/bram_stream_reader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared types, FIFO depth and ones-complement add for bram_stream_reader
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - output beat stream of bram_stream_reader (master drives, slave sinks)
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int BYTES_WIDTH = 3
);
  logic                   tvalid;
  logic [DATA_WIDTH-1:0]  tdata;
  logic                   tlast;
  logic [BYTES_WIDTH-1:0] tbytes;
  logic                   tready;

  modport master (output tvalid, tdata, tlast, tbytes, input tready);
  modport slave  (input tvalid, tdata, tlast, tbytes, output tready);
endinterface

// File: rtl/bram_stream_reader_skid_fifo2.sv
// rtl/bram_stream_reader_skid_fifo2.sv - 2-entry FIFO holding data/last/bytes with synchronous flush
module skid_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BYTES_WIDTH = 3
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_last,
  input  logic [BYTES_WIDTH-1:0] i_bytes,
  input  logic                   i_pop,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_last,
  output logic [BYTES_WIDTH-1:0] o_bytes,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [DATA_WIDTH-1:0]  data_q  [FIFO_DEPTH];
  logic [BYTES_WIDTH-1:0] bytes_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  last_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;
  logic                   do_push, do_pop;

  assign o_full  = (count_q == 2'd2);
  assign o_empty = (count_q == 2'd0);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | i_pop);

  // Head entry is read in place so it stays stable until popped.
  assign o_data  = data_q[rd_ptr_q];
  assign o_last  = last_q[rd_ptr_q];
  assign o_bytes = bytes_q[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i]  <= '0;
        bytes_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (i_flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q]  <= i_data;
        last_q[wr_ptr_q]  <= i_last;
        bytes_q[wr_ptr_q] <= i_bytes;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - frame reader from a 1-cycle-latency BRAM port to a beat stream
// Optional ones-complement checksum output enabled by BRAM_STREAM_READER_CSUM_EN.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int BYTES_WIDTH = 3
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [ADDR_WIDTH:0]    i_word_count,
  input  logic [BYTES_WIDTH-1:0] i_last_bytes,
  output logic                   o_ram_en,
  output logic [ADDR_WIDTH-1:0]  o_ram_addr,
  input  logic [DATA_WIDTH-1:0]  i_ram_data,
  bram_stream_reader_if.master   strm,
  output logic                   o_busy,
  output logic                   o_done
`ifdef BRAM_STREAM_READER_CSUM_EN
  ,
  output logic [15:0]            o_csum
`endif
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH:0]    left_q, left_d;
  logic [BYTES_WIDTH-1:0] last_bytes_q, last_bytes_d;
  logic                   inflight_q, inflight_last_q;
  logic                   fifo_full, fifo_empty;
  logic [1:0]             fifo_occ, used;
  logic                   abort_act, pop, issue, last_issue, start_acc;

  assign start_acc  = (state_q == IDLE) & i_start;
  assign abort_act  = i_abort & (state_q != IDLE);
  assign pop        = strm.tvalid & strm.tready & ~abort_act;
  assign fifo_occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // A beat popped this cycle frees its slot in time for a new read, giving full rate.
  assign used       = fifo_occ + {1'b0, inflight_q} - {1'b0, pop};
  assign issue      = (state_q == READ) & ~i_abort & (used < 2'd2);
  assign last_issue = issue & (left_q == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_start) state_d = (i_word_count == '0) ? DONE : READ;
      READ:  if (last_issue) state_d = DRAIN;
      DRAIN: if (~inflight_q & (fifo_empty | (~fifo_full & pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_act && state_q != DONE) state_d = DONE;
  end

  always_comb begin
    o_ram_en   = issue;
    o_ram_addr = addr_q;
    o_busy     = (state_q != IDLE);
    o_done     = (state_q == DONE);
  end

  always_comb begin
    addr_d       = addr_q;
    left_d       = left_q;
    last_bytes_d = last_bytes_q;
    if (start_acc) begin
      addr_d       = i_base_addr;
      left_d       = i_word_count;
      last_bytes_d = i_last_bytes;
    end else if (issue) begin
      addr_d = addr_q + 1'b1;
      left_d = left_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      addr_q          <= '0;
      left_q          <= '0;
      last_bytes_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      left_q          <= left_d;
      last_bytes_q    <= last_bytes_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  assign strm.tvalid = ~fifo_empty;

  skid_fifo2 #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTES_WIDTH (BYTES_WIDTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_flush    (abort_act),
    .i_push     (inflight_q),
    .i_data     (i_ram_data),
    .i_last     (inflight_last_q),
    .i_bytes    (inflight_last_q ? last_bytes_q : '0),
    .i_pop      (pop),
    .o_data     (strm.tdata),
    .o_last     (strm.tlast),
    .o_bytes    (strm.tbytes),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

`ifdef BRAM_STREAM_READER_CSUM_EN
  logic [15:0] csum_q, csum_d, lane;

  // Lanes are big-endian 16-bit slices from the MSB; tbytes counts valid bytes from the MSB.
  always_comb begin
    csum_d = csum_q;
    lane   = '0;
    if (start_acc) begin
      csum_d = '0;
    end else if (pop) begin
      for (int l = 0; l < DATA_WIDTH/16; l++) begin
        lane = strm.tdata[DATA_WIDTH-1-16*l -: 16];
        if (strm.tbytes != '0) begin
          if (2*l >= int'(strm.tbytes))        lane = '0;
          else if (2*l+1 >= int'(strm.tbytes)) lane[7:0] = '0;
        end
        csum_d = ones_add(csum_d, lane);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) csum_q <= '0;
    else             csum_q <= csum_d;
  end

  assign o_csum = csum_q;
`endif

endmodule
